simon_response_checker: RTL and testbench
=========================================

// Module: simon_response_checker
// PURPOSE
//  Player-turn end of the Simon exchange. Simon plays a sequence out; this block takes the player's
//  responses back in and checks them step by step against stored sequence memory.
//  Debounces each press, checks timing, and reports round success or game over to the Simon sequencer.
// PARAMETERS
//  MAX_LEN   10        max sequence length; equals sequence memory depth
//  DEBOUNCE  250000    cycles press must stay stable before it is accepted
//  TIMEOUT   150000000 cycles allowed between turn/step start and a press
// PORTS
//  clk           in   1  system clock; only clock domain
//  reset         in   1  synchronous, active-high; sampled on rising clk
//  start         in   1  one-cycle pulse from Simon: playback done, player turn begins
//  seq_len       in   4  current round length, sampled on accepted start
//  seq_rd_addr   out  4  memory read index (= step_idx); combinational read
//  seq_rd_data   in   2  expected number at seq_rd_addr, valid same cycle
//  player_num    in   2  decoded button number
//  player_pressed in  1  level, high while any button held
//  busy          out  1  high while player turn in progress
//  step_idx      out  4  current step, 0..seq_len-1
//  round_ok      out  1  one-cycle pulse: full sequence matched
//  game_over     out  1  sticky fail flag; cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE; busy=0, step_idx=0, round_ok=0, game_over=0; timers cleared. Applies mid-operation too.
//  States: IDLE, WAIT_PRESS, DEBOUNCE, WAIT_RELEASE, FAIL.
//  IDLE: start & 1<=seq_len<=MAX_LEN -> WAIT_PRESS, step_idx=0, timeout timer=0, busy=1.
//    Start with seq_len=0 or >MAX_LEN is ignored. Start in any other state is ignored.
//  WAIT_PRESS: timer increments each cycle.
//    If player_pressed=1 -> latch player_num, clear debounce counter, go to DEBOUNCE.
//    Else, when timer reaches TIMEOUT-1 -> FAIL.
//    If both occur in the same cycle, the press wins.
//  DEBOUNCE: timeout timer keeps running.
//    player_pressed drops -> WAIT_PRESS; glitch discarded, timer NOT reset.
//    player_num changes -> relatch it and restart the debounce count.
//    Count reaches DEBOUNCE-1: latched num != seq_rd_data -> FAIL; otherwise -> WAIT_RELEASE.
//    Timeout firing in DEBOUNCE -> FAIL; a mismatch and a timeout together also -> FAIL.
//  WAIT_RELEASE: no timeout. On the edge that samples player_pressed=0:
//    If step_idx==seq_len-1 -> round_ok=1 for one cycle, busy=0, step_idx=0, go to IDLE.
//    Otherwise step_idx+1, timer=0, go to WAIT_PRESS.
//  FAIL: game_over=1, busy=0; stays until reset. round_ok never asserts here.
//  Latency:
//    Press accepted DEBOUNCE cycles after the first sampled high.
//    round_ok registered, high the cycle after release is sampled.
//  Widths:
//    Timers are $clog2(TIMEOUT) and $clog2(DEBOUNCE) bits, with a terminal compare and no wrap.
//    step_idx is 4 bits; MAX_LEN<=15 enforced by elaboration check.
// STRUCTURE
//  simon_defs.vh: state encodings, NUM_W=2, IDX_W=4, MAX_LEN default.
//  Sub-module simon_press_filter: debounce counter, num relatch, and stable-press output.
//  The FSM and timeout timer stay in the top of this block.
// TESTING (sim params DEBOUNCE=4, TIMEOUT=50, MAX_LEN=10)
//  Memory {2,0,3}, start with seq_len=3; press 2,0,3, each held 6 cycles with gaps.
//    -> one round_ok pulse, busy 1->0, game_over=0.
//  Same memory; second press is 1.
//    -> game_over=1 four cycles after that press, busy=0, later start ignored.
//  start with seq_len=2, then no press.
//    -> game_over=1 at cycle 50 after start; round_ok never asserts.
//  A 2-cycle glitch press of 2, then a clean press of 2.
//    -> glitch ignored, timer not reset, step_idx advances only after the clean release.
//  reset asserted in DEBOUNCE at step 1.
//    -> next cycle all outputs 0, state IDLE; a new start works normally.
//  start with seq_len=0 and with seq_len=11; start pulsed again while busy.
//    -> all ignored, with no output change.

Source files
------------

// File: rtl/simon_response_checker_pkg.sv
// rtl/simon_response_checker_pkg.sv - shared widths, defaults and FSM states for the response checker
package simon_response_checker_pkg;

  localparam int NUM_W       = 2;
  localparam int IDX_W       = 4;
  localparam int MAX_LEN_DEF = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PRESS,
    S_DEBOUNCE,
    S_WAIT_RELEASE,
    S_FAIL
  } state_e;

endpackage

// File: rtl/simon_response_checker_press_filter.sv
// rtl/simon_response_checker_press_filter.sv - debounce counter with button-number relatch
module simon_response_checker_press_filter
  import simon_response_checker_pkg::*;
#(
  parameter int DEBOUNCE = 250000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [NUM_W-1:0] num_i,
  output logic [NUM_W-1:0] num_o,
  output logic             stable_o
);

  localparam int CNT_W = $clog2(DEBOUNCE);

  logic [CNT_W-1:0] cnt_q;
  logic [NUM_W-1:0] num_q;
  logic             cnt_end;

  assign cnt_end = (cnt_q == CNT_W'(DEBOUNCE - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      num_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
      num_q <= num_i;
    end else if (run_i) begin
      // A different button mid-press restarts the stability window.
      if (num_i != num_q) begin
        cnt_q <= '0;
        num_q <= num_i;
      end else if (!cnt_end) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign num_o    = num_q;
  assign stable_o = cnt_end && (num_i == num_q);

endmodule

// File: rtl/simon_response_checker.sv
// rtl/simon_response_checker.sv - player-turn checker: debounced presses vs. sequence memory, with timeout
module simon_response_checker
  import simon_response_checker_pkg::*;
#(
  parameter int MAX_LEN  = MAX_LEN_DEF,
  parameter int DEBOUNCE = 250000,
  parameter int TIMEOUT  = 150000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] seq_len,
  output logic [IDX_W-1:0] seq_rd_addr,
  input  logic [NUM_W-1:0] seq_rd_data,
  input  logic [NUM_W-1:0] player_num,
  input  logic             player_pressed,
  output logic             busy,
  output logic [IDX_W-1:0] step_idx,
  output logic             round_ok,
  output logic             game_over
);

  localparam int               TMR_W     = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] MAX_LEN_V = IDX_W'(MAX_LEN);

  if (MAX_LEN < 1 || MAX_LEN > 15 || DEBOUNCE < 2 || TIMEOUT < 2) begin : g_param_check
    $error("simon_response_checker: MAX_LEN must be 1..15, DEBOUNCE and TIMEOUT at least 2");
  end

  state_e           state_q;
  logic [IDX_W-1:0] step_q, len_q;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             busy_q, round_ok_q, game_over_q;
  logic             timer_end, press_stable;
  logic [NUM_W-1:0] press_num;

  simon_response_checker_press_filter #(.DEBOUNCE(DEBOUNCE)) u_filter (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_i   (state_q == S_WAIT_PRESS && player_pressed),
    .run_i    (state_q == S_DEBOUNCE),
    .num_i    (player_num),
    .num_o    (press_num),
    .stable_o (press_stable)
  );

  // The timer saturates at its terminal count rather than wrapping.
  assign timer_end = (timer_q == TMR_W'(TIMEOUT - 1));
  assign timer_d   = timer_end ? timer_q : timer_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      len_q       <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      round_ok_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      round_ok_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && seq_len != '0 && seq_len <= MAX_LEN_V) begin
            state_q <= S_WAIT_PRESS;
            len_q   <= seq_len;
            step_q  <= '0;
            timer_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_WAIT_PRESS: begin
          if (player_pressed) begin
            state_q <= S_DEBOUNCE;
            timer_q <= timer_d;
          end else if (timer_end) begin
            state_q     <= S_FAIL;
            busy_q      <= 1'b0;
            game_over_q <= 1'b1;
          end else begin
            timer_q <= timer_d;
          end
        end
        S_DEBOUNCE: begin
          if (timer_end) begin
            state_q     <= S_FAIL;
            busy_q      <= 1'b0;
            game_over_q <= 1'b1;
          end else begin
            timer_q <= timer_d;
            if (!player_pressed) begin
              state_q <= S_WAIT_PRESS;
            end else if (press_stable) begin
              if (press_num != seq_rd_data) begin
                state_q     <= S_FAIL;
                busy_q      <= 1'b0;
                game_over_q <= 1'b1;
              end else begin
                state_q <= S_WAIT_RELEASE;
              end
            end
          end
        end
        S_WAIT_RELEASE: begin
          if (!player_pressed) begin
            if (step_q == len_q - 1'b1) begin
              state_q    <= S_IDLE;
              step_q     <= '0;
              busy_q     <= 1'b0;
              round_ok_q <= 1'b1;
            end else begin
              state_q <= S_WAIT_PRESS;
              step_q  <= step_q + 1'b1;
              timer_q <= '0;
            end
          end
        end
        S_FAIL: begin
          busy_q      <= 1'b0;
          game_over_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign seq_rd_addr = step_q;
  assign step_idx    = step_q;
  assign busy        = busy_q;
  assign round_ok    = round_ok_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_simon_response_checker.sv
// tb/tb_simon_response_checker.sv - randomized and directed bench for simon_response_checker
module tb_simon_response_checker;

  localparam int MAX_LEN  = 10;
  localparam int DEBOUNCE = 4;
  localparam int TIMEOUT  = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] seq_len = '0;
  logic [3:0] seq_rd_addr;
  logic [1:0] seq_rd_data;
  logic [1:0] player_num = '0;
  logic       player_pressed = 1'b0;
  logic       busy;
  logic [3:0] step_idx;
  logic       round_ok;
  logic       game_over;

  logic [1:0] mem [16];

  int n_checks = 0;
  int n_errors = 0;
  int ok_seen  = 0;

  // Reference model: elapsed time in the step, samples the current press has been held,
  // and whether the current step's press has been accepted.
  bit         m_active, m_failed, m_accepted, m_round_ok;
  int         m_step, m_len, m_elapsed, m_hold;
  logic [1:0] m_num;

  always #5 clk = ~clk;

  assign seq_rd_data = mem[seq_rd_addr];

  simon_response_checker #(
    .MAX_LEN (MAX_LEN),
    .DEBOUNCE(DEBOUNCE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .seq_len       (seq_len),
    .seq_rd_addr   (seq_rd_addr),
    .seq_rd_data   (seq_rd_data),
    .player_num    (player_num),
    .player_pressed(player_pressed),
    .busy          (busy),
    .step_idx      (step_idx),
    .round_ok      (round_ok),
    .game_over     (game_over)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    m_round_ok = 1'b0;
    if (reset) begin
      m_active = 0; m_failed = 0; m_accepted = 0;
      m_step = 0; m_elapsed = 0; m_hold = 0;
    end else if (m_failed) begin
      m_active = 0;
    end else if (!m_active) begin
      if (start && seq_len >= 1 && seq_len <= MAX_LEN) begin
        m_active = 1; m_len = int'(seq_len);
        m_step = 0; m_elapsed = 0; m_hold = 0; m_accepted = 0;
      end
    end else if (m_accepted) begin
      if (!player_pressed) begin
        if (m_step == m_len - 1) begin
          m_round_ok = 1'b1; m_active = 0; m_step = 0;
        end else begin
          m_step++; m_elapsed = 0;
        end
        m_hold = 0; m_accepted = 0;
      end
    end else if (m_hold == 0) begin
      if (player_pressed) begin
        m_hold = 1; m_num = player_num;
        if (m_elapsed < TIMEOUT - 1) m_elapsed++;
      end else if (m_elapsed == TIMEOUT - 1) begin
        m_failed = 1; m_active = 0;
      end else begin
        m_elapsed++;
      end
    end else begin
      if (m_elapsed == TIMEOUT - 1) begin
        m_failed = 1; m_active = 0;
      end else begin
        m_elapsed++;
        if (!player_pressed) m_hold = 0;
        else if (player_num != m_num) begin
          m_num = player_num; m_hold = 1;
        end else if (m_hold == DEBOUNCE) begin
          if (m_num != mem[m_step]) begin
            m_failed = 1; m_active = 0;
          end else m_accepted = 1;
        end else m_hold++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (round_ok === 1'b1) ok_seen++;
    check("busy", busy, m_active);
    check("step_idx", step_idx, m_step);
    check("seq_rd_addr", seq_rd_addr, m_step);
    check("round_ok", round_ok, m_round_ok);
    check("game_over", game_over, m_failed);
  endtask

  task automatic idle(input int n);
    player_pressed = 1'b0;
    repeat (n) tick();
  endtask

  task automatic press_keep(input logic [1:0] v, input int n);
    player_num = v;
    player_pressed = 1'b1;
    repeat (n) tick();
  endtask

  task automatic press(input logic [1:0] v, input int n);
    press_keep(v, n);
    player_pressed = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    seq_len = 4'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    player_pressed = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_mem3();
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
  endtask

  initial begin
    int n, ok_before, guard, len, sel, h;
    logic [1:0] v;

    set_mem3();
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_step", step_idx, 0);
    check("rst_round_ok", round_ok, 0);
    check("rst_game_over", game_over, 0);

    // Full correct round.
    ok_before = ok_seen;
    pulse_start(3);
    check("start_busy", busy, 1);
    press(2'd2, 6); idle(3);
    press(2'd0, 6); idle(3);
    press(2'd3, 6); idle(3);
    check("round_ok_count", ok_seen - ok_before, 1);
    check("round_busy_end", busy, 0);
    check("round_game_over", game_over, 0);

    // Wrong second press.
    do_reset();
    pulse_start(3);
    press(2'd2, 6); idle(2);
    press_keep(2'd1, 1);
    n = 0;
    while (game_over !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("fail_latency", n, 4);
    idle(2);
    check("fail_busy", busy, 0);
    pulse_start(3); idle(2);
    check("fail_start_ignored", busy, 0);
    check("fail_sticky", game_over, 1);

    // No press at all: timeout.
    do_reset();
    ok_before = ok_seen;
    pulse_start(2);
    n = 0;
    while (game_over !== 1'b1 && n < 70) begin
      tick();
      n++;
    end
    check("timeout_cycle", n, 50);
    check("timeout_no_round_ok", ok_seen - ok_before, 0);

    // Glitch press then clean press.
    do_reset();
    pulse_start(3);
    idle(10);
    press(2'd2, 2); idle(4);
    check("glitch_step", step_idx, 0);
    press(2'd2, 6);
    check("held_step", step_idx, 0);
    idle(1);
    check("clean_step", step_idx, 1);

    // Reset while debouncing step 1.
    do_reset();
    pulse_start(3);
    press(2'd2, 6); idle(2);
    press_keep(2'd0, 2);
    do_reset();
    check("midrst_busy", busy, 0);
    check("midrst_step", step_idx, 0);
    check("midrst_game_over", game_over, 0);
    ok_before = ok_seen;
    pulse_start(3);
    press(2'd2, 6); idle(1);
    press(2'd0, 6); idle(1);
    press(2'd3, 6); idle(2);
    check("midrst_round", ok_seen - ok_before, 1);

    // Invalid lengths and start while busy.
    pulse_start(0); idle(2);
    check("len0_ignored", busy, 0);
    pulse_start(11); idle(2);
    check("len11_ignored", busy, 0);
    pulse_start(3);
    press(2'd2, 6); idle(1);
    pulse_start(1);
    check("busy_start_step", step_idx, 1);
    press(2'd0, 6); idle(1);
    press(2'd3, 6); idle(2);
    check("busy_start_busy", busy, 0);

    // Randomized rounds.
    for (int r = 0; r < 150; r++) begin
      if (game_over === 1'b1) do_reset();
      for (int i = 0; i < 16; i++) mem[i] = 2'($urandom);
      if ($urandom_range(0, 9) == 0) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(11, 15);
      else len = $urandom_range(1, MAX_LEN);
      pulse_start(len);
      guard = 0;
      while (busy === 1'b1 && guard < 200) begin
        guard++;
        idle($urandom_range(0, 6));
        sel = $urandom_range(0, 99);
        h = $urandom_range(1, 9);
        v = (sel < 88) ? mem[step_idx] : 2'($urandom);
        if (sel < 2) idle(TIMEOUT + 5);
        else if (sel < 5) pulse_start($urandom_range(1, MAX_LEN));
        else if (sel >= 94 && h > 2) begin
          press_keep(2'($urandom), h / 2);
          press(v, h);
        end else press(v, h);
      end
      idle(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
